// File: rtl/spi_rom_arbiter.sv
// spi_rom_arbiter: shares one SPI/QSPI flash port between two requesters, running
// one 03h (single) or 6Bh (quad output) read per grant and streaming tagged bytes back.
module spi_rom_arbiter #(
  parameter int CS_GAP = 2,
  parameter int FAIR = 0,
  parameter int QSPI_DUMMY = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        r0_req,
  input  logic [23:0] r0_addr,
  input  logic [7:0]  r0_len,
  input  logic        r0_quad,
  output logic        r0_ack,
  input  logic        r1_req,
  input  logic [23:0] r1_addr,
  input  logic [7:0]  r1_len,
  input  logic        r1_quad,
  output logic        r1_ack,
  output logic        busy,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_id,
  output logic        rd_last,
  output logic        spi_cs,
  output logic        spi_sclk,
  input  logic [3:0]  spi_in,
  output logic        spi_out0,
  output logic        spi_dir0
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, GAP} state_t;
  state_t state, state_nx;
  logic [1:0] rst_sync;
  logic rst_n_s, ph, quad, owner, last, act, grant, g1, byte_end;
  logic [5:0] bcnt;
  logic [3:0] gcnt;
  logic [8:0] rem;
  logic [31:0] sh;
  logic [7:0] dsh, din, lsel;
  // Assertion is immediate, release is re-timed to clk.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n_s = rst_sync[1];
  assign act = state == CMD || state == ADDR || state == DUMMY || state == DATA;
  assign grant = state == IDLE && (r0_req || r1_req);
  assign g1 = r1_req && (!r0_req || (FAIR != 0 && !last));
  assign lsel = g1 ? r1_len : r0_len;
  assign byte_end = state == DATA && ph && bcnt == (quad ? 6'd1 : 6'd7);
  assign din = quad ? {dsh[3:0], spi_in} : {dsh[6:0], spi_in[1]};
  assign busy = state != IDLE;
  assign spi_cs = act;
  assign spi_sclk = act && ph;
  assign spi_out0 = (state == CMD || state == ADDR) && sh[31];
  assign spi_dir0 = state == DUMMY || (state == DATA && quad);
  always_ff @(posedge clk or negedge rst_n_s)
    if (!rst_n_s) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant ? CMD : IDLE;
      CMD:     state_nx = ph && bcnt == 6'd7 ? ADDR : CMD;
      ADDR:    state_nx = ph && bcnt == 6'd23 ? (quad ? DUMMY : DATA) : ADDR;
      DUMMY:   state_nx = ph && bcnt == 6'(QSPI_DUMMY - 1) ? DATA : DUMMY;
      DATA:    state_nx = byte_end && rem == 9'd1 ? GAP : DATA;
      GAP:     state_nx = gcnt == 4'(CS_GAP - 1) ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n_s)
    if (!rst_n_s) begin
      {r0_ack, r1_ack, rd_valid, rd_last, rd_id, ph, quad, owner} <= '0;
      last <= 1'b1;
      {rd_data, dsh, sh, rem, bcnt, gcnt} <= '0;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      ph <= act && !ph;
      gcnt <= state == GAP ? gcnt + 4'd1 : 4'd0;
      if (grant) begin
        owner <= g1;
        last <= g1;
        quad <= g1 ? r1_quad : r0_quad;
        sh <= {(g1 ? r1_quad : r0_quad) ? 8'h6B : 8'h03, g1 ? r1_addr : r0_addr};
        rem <= {lsel == 8'd0, lsel};
        r0_ack <= !g1;
        r1_ack <= g1;
        bcnt <= 6'd0;
      end else if (act && ph) begin
        bcnt <= (state_nx != state || byte_end) ? 6'd0 : bcnt + 6'd1;
        if (state == CMD || state == ADDR) sh <= {sh[30:0], 1'b0};
        if (state == DATA) dsh <= din;
        if (byte_end) begin
          rd_valid <= 1'b1;
          rd_data <= din;
          rd_id <= owner;
          rd_last <= rem == 9'd1;
          rem <= rem - 9'd1;
        end
      end
    end
endmodule

// File: tb/tb_spi_rom_arbiter.sv
// tb_spi_rom_arbiter: directed checks of the flash read arbiter against a small flash model.
module tb_spi_rom_arbiter;
  localparam int CS_GAP = 2;
  logic clk = 0;
  logic reset_n = 0;
  logic r0_req = 0, r0_quad = 0, r1_req = 0, r1_quad = 0;
  logic [23:0] r0_addr = 0, r1_addr = 0;
  logic [7:0] r0_len = 0, r1_len = 0;
  logic r0_ack, r1_ack, busy, rd_valid, rd_id, rd_last, spi_cs, spi_sclk, spi_out0, spi_dir0;
  logic [7:0] rd_data;
  logic [3:0] spi_in = 0;
  logic f0_req = 0, f1_req = 0;
  logic f0_ack, f1_ack, f_busy, f_valid, f_id, f_last, f_cs, f_sclk, f_out0, f_dir0;
  logic [7:0] f_data;
  int total = 0, bad = 0;
  logic [7:0] pat [256];
  int n = 0, j = 0, sclk_bad = 0;
  logic [7:0] b, m_cmd = 0;
  logic [23:0] m_addr = 0;
  int cur = 0, cs_len = 0, dir_first = -1, gap_cur = 0, last_gap = 0;
  int rx_n = 0, n_last = 0, n_ack0 = 0, n_ack1 = 0;
  logic [7:0] rx_data [1024];
  logic rx_id [1024], rx_last [1024];
  int b_rx, b_l, b_a0, b_a1, k_ack, errs;
  logic got, who, found;
  logic [7:0] e2 [4];

  spi_rom_arbiter #(.CS_GAP(CS_GAP), .FAIR(0), .QSPI_DUMMY(8)) u0 (
    .clk(clk), .reset_n(reset_n),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_len(r0_len), .r0_quad(r0_quad), .r0_ack(r0_ack),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_len(r1_len), .r1_quad(r1_quad), .r1_ack(r1_ack),
    .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id), .rd_last(rd_last),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_in(spi_in), .spi_out0(spi_out0), .spi_dir0(spi_dir0));

  spi_rom_arbiter #(.CS_GAP(CS_GAP), .FAIR(1), .QSPI_DUMMY(8)) uf (
    .clk(clk), .reset_n(reset_n),
    .r0_req(f0_req), .r0_addr(r0_addr), .r0_len(r0_len), .r0_quad(r0_quad), .r0_ack(f0_ack),
    .r1_req(f1_req), .r1_addr(r1_addr), .r1_len(r1_len), .r1_quad(r1_quad), .r1_ack(f1_ack),
    .busy(f_busy), .rd_data(f_data), .rd_valid(f_valid), .rd_id(f_id), .rd_last(f_last),
    .spi_cs(f_cs), .spi_sclk(f_sclk), .spi_in(spi_in), .spi_out0(f_out0), .spi_dir0(f_dir0));

  always #5 clk = ~clk;

  // Flash model: captures CMD/ADDR on SCLK rise, presents read data for the next falling-edge sample.
  always @(posedge spi_sclk or posedge spi_cs) begin
    if (!spi_sclk) begin
      n = 0; m_cmd = 0; m_addr = 0; spi_in = 0;
    end else begin
      if (!spi_cs) sclk_bad++;
      if (n < 8) m_cmd = {m_cmd[6:0], spi_out0};
      else if (n < 32) m_addr = {m_addr[22:0], spi_out0};
      else if (m_cmd == 8'h6B) begin
        if (n >= 40) begin
          j = n - 40; b = pat[(j / 2) % 256];
          spi_in = (j % 2 == 0) ? b[7:4] : b[3:0];
        end
      end else begin
        j = n - 32; b = pat[(j / 8) % 256];
        spi_in = {2'b00, b[7 - (j % 8)], 1'b0};
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (spi_cs) begin
      if (cur == 0) begin dir_first = -1; last_gap = gap_cur; end
      if (spi_dir0 && dir_first < 0) dir_first = cur;
      cur++; gap_cur = 0;
    end else begin
      if (cur > 0) cs_len = cur;
      cur = 0; gap_cur++;
    end
    if (rd_valid && rx_n < 1024) begin
      rx_data[rx_n] = rd_data; rx_id[rx_n] = rd_id; rx_last[rx_n] = rd_last; rx_n++;
    end
    if (rd_last) n_last++;
    if (r0_ack) n_ack0++;
    if (r1_ack) n_ack1++;
  end

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic snap();
    b_rx = rx_n; b_l = n_last; b_a0 = n_ack0; b_a1 = n_ack1;
  endtask

  task automatic req(input logic p, input logic [23:0] a, input logic [7:0] l, input logic q);
    logic seen;
    seen = 0;
    @(negedge clk);
    if (p) begin r1_addr = a; r1_len = l; r1_quad = q; r1_req = 1; end
    else begin r0_addr = a; r0_len = l; r0_quad = q; r0_req = 1; end
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = p ? r1_ack : r0_ack;
    end
    r0_req = 0; r1_req = 0;
    chk("ack_seen", 32'(seen), 1);
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 0;
    for (int k = 0; k < 6000 && !idle; k++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk("idle_reached", 32'(idle), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(spi_cs), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_sclk", 32'(spi_sclk), 0);
    reset_n = 1;
    repeat (4) @(negedge clk);

    snap(); pat[0] = 8'hA5; pat[1] = 8'h3C;
    req(0, 24'h000120, 8'd2, 0); wait_idle();
    chk("t1_cmd", 32'(m_cmd), 32'h03);
    chk("t1_addr", 32'(m_addr), 32'h000120);
    chk("t1_cs_len", cs_len, 96);
    chk("t1_count", rx_n - b_rx, 2);
    chk("t1_b0", 32'(rx_data[b_rx]), 32'hA5);
    chk("t1_b1", 32'(rx_data[b_rx + 1]), 32'h3C);
    chk("t1_last", 32'({rx_last[b_rx], rx_last[b_rx + 1]}), 1);
    chk("t1_id", 32'({rx_id[b_rx], rx_id[b_rx + 1]}), 0);
    chk("t1_ack0", n_ack0 - b_a0, 1);
    chk("t1_ack1", n_ack1 - b_a1, 0);
    chk("t1_dir", dir_first, -1);

    snap(); e2 = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 4; i++) pat[i] = e2[i];
    req(1, 24'h001040, 8'd4, 1); wait_idle();
    chk("t2_cmd", 32'(m_cmd), 32'h6B);
    chk("t2_addr", 32'(m_addr), 32'h001040);
    chk("t2_dir_first", dir_first, 64);
    chk("t2_cs_len", cs_len, 96);
    chk("t2_count", rx_n - b_rx, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_b%0d", i), 32'(rx_data[b_rx + i]), 32'(e2[i]));
      chk($sformatf("t2_id%0d", i), 32'(rx_id[b_rx + i]), 1);
    end
    chk("t2_last_pos", 32'(rx_last[b_rx + 3]), 1);
    chk("t2_last_cnt", n_last - b_l, 1);
    chk("t2_ack1", n_ack1 - b_a1, 1);

    snap(); r0_len = 1; r1_len = 1; r0_quad = 0; r1_quad = 0;
    for (int r = 0; r < 3; r++) begin
      got = 0; who = 0;
      @(negedge clk); r0_req = 1; r1_req = 1;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk); got = r0_ack | r1_ack; who = r1_ack;
      end
      r0_req = 0; r1_req = 0;
      chk("fix_ack", 32'(got), 1);
      chk("fix_grant", 32'(who), 0);
      #1;
      if (r > 0) chk("fix_gap", 32'(last_gap >= CS_GAP), 1);
      wait_idle();
    end
    chk("fix_r1_never", n_ack1 - b_a1, 0);

    for (int r = 0; r < 3; r++) begin
      got = 0; who = 0;
      @(negedge clk); f0_req = 1; f1_req = 1;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk); got = f0_ack | f1_ack; who = f1_ack;
      end
      f0_req = 0; f1_req = 0;
      chk("fair_ack", 32'(got), 1);
      chk("fair_grant", 32'(who), 32'(r == 1));
      found = 0;
      for (int k = 0; k < 2000 && !found; k++) begin @(negedge clk); found = !f_busy; end
      chk("fair_idle", 32'(found), 1);
    end

    snap();
    for (int i = 0; i < 256; i++) pat[i] = 8'(i) ^ 8'h5A;
    req(0, 24'hABCDEF, 8'd0, 0); wait_idle();
    chk("t4_count", rx_n - b_rx, 256);
    chk("t4_last_cnt", n_last - b_l, 1);
    chk("t4_last_pos", 32'(rx_last[b_rx + 255]), 1);
    chk("t4_cs_len", cs_len, 2 * (32 + 2048));
    errs = 0;
    for (int i = 0; i < 256; i++) if (rx_data[b_rx + i] !== (8'(i) ^ 8'h5A)) errs++;
    chk("t4_data_errs", errs, 0);

    snap();
    for (int i = 0; i < 8; i++) pat[i] = 8'(8'h90 + i);
    req(0, 24'h000010, 8'd8, 0);
    for (int k = 0; k < 3000 && rx_n - b_rx < 3; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    #2;
    chk("t5_cs_before", 32'(spi_cs), 1);
    reset_n = 0;
    #1;
    chk("t5_cs_async", 32'(spi_cs), 0);
    chk("t5_sclk_async", 32'(spi_sclk), 0);
    chk("t5_valid_async", 32'(rd_valid), 0);
    chk("t5_busy_async", 32'(busy), 0);
    repeat (5) @(negedge clk);
    chk("t5_count", rx_n - b_rx, 3);
    chk("t5_no_last", n_last - b_l, 0);
    reset_n = 1;
    repeat (4) @(negedge clk);
    snap(); pat[0] = 8'hC3; pat[1] = 8'h18;
    req(1, 24'h000200, 8'd2, 0); wait_idle();
    chk("t5b_addr", 32'(m_addr), 32'h000200);
    chk("t5b_count", rx_n - b_rx, 2);
    chk("t5b_b0", 32'(rx_data[b_rx]), 32'hC3);
    chk("t5b_b1", 32'(rx_data[b_rx + 1]), 32'h18);
    chk("t5b_last", 32'(rx_last[b_rx + 1]), 1);
    chk("t5b_id", 32'(rx_id[b_rx + 1]), 1);
    chk("t5b_cs_len", cs_len, 96);

    req(0, 24'h000300, 8'd1, 0);
    found = 0;
    for (int k = 0; k < 500 && !found; k++) begin @(negedge clk); found = !spi_cs && busy; end
    chk("t6_gap_seen", 32'(found), 1);
    r1_addr = 24'h000400; r1_len = 1; r1_quad = 0; r1_req = 1;
    got = 0; k_ack = 0;
    for (int k = 0; k < 20 && !got; k++) begin @(negedge clk); k_ack++; got = r1_ack; end
    #1;
    r1_req = 0;
    chk("t6_ack_delay", k_ack, CS_GAP + 1);
    chk("t6_gap_low", 32'(last_gap >= CS_GAP), 1);
    wait_idle();

    chk("sclk_only_with_cs", sclk_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_rom_arbiter.md
Name: spi_rom_arbiter

Overview:
- Shares one SPI/QSPI flash ROM port between two requesters: port 0 (video line prefetch, high priority) and port 1 (host/debug reader).
- Per granted request, runs one complete flash read (03h single-SPI or 6Bh quad output): CMD, ADDR, optional dummy, then N data bytes.
- Returns data as a tagged byte stream; sits between the VGA line-buffer logic and the flash pads.

Parameters:
- CS_GAP, 2, minimum clk cycles spi_cs stays low between transactions (1..15).
- FAIR, 0, 0 = fixed priority (port 0 wins); 1 = round-robin (last-served port loses ties).
- QSPI_DUMMY, 8, dummy SCLKs after ADDR in quad mode.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- r0_req  in  1  port 0 request; hold until r0_ack.
- r0_addr  in  24  port 0 byte address.
- r0_len  in  8  port 0 byte count; 0 means 256.
- r0_quad  in  1  port 0 mode: 1 = 6Bh quad, 0 = 03h single.
- r0_ack  out  1  one-cycle pulse: port 0 request captured.
- r1_req, r1_addr, r1_len, r1_quad, r1_ack  same as port 0, for port 1.
- busy  out  1  high from grant until the end of the CS_GAP.
- rd_data  out  8  returned byte, MSB first as received.
- rd_valid  out  1  one-cycle strobe: rd_data valid.
- rd_id  out  1  owning port of rd_data.
- rd_last  out  1  with rd_valid on the final byte of a transaction.
- spi_cs  out  1  chip select, active HIGH; the parent inverts it.
- spi_sclk  out  1  SPI clock, clk/2, idle low (mode 0).
- spi_in  in  4  io[3:0] input side; io[1] is MISO.
- spi_out0  out  1  io0 output (MOSI).
- spi_dir0  out  1  io0 output enable; 0 = drive, 1 = input.

Behaviour:
- Reset (asynchronous assert): all outputs 0 immediately; FSM returns to IDLE; round-robin pointer favours port 0. An in-flight transaction is dropped (no rd_last). Reset deassertion is synchronised internally (2 flops).
- States: IDLE -> CMD -> ADDR -> [DUMMY, quad only] -> DATA -> GAP -> IDLE.
- IDLE, any request pending: on the next clk edge, latch addr, len, quad and owner; pulse rN_ack; spi_cs=1; enter CMD. Arbitration follows FAIR. Both requests in the same cycle with FAIR=1: the port not served last wins.
- Bit timing: each SPI bit is 2 clks.
  - Phase L: sclk=0; MOSI updates.
  - Phase H: sclk=1.
  - Inputs are sampled on the clk edge that ends phase H (sclk falling).
- CMD: 8 bits, 8'h03 or 8'h6B, MSB first (16 clks).
- ADDR: 24 bits, MSB first (48 clks).
- DUMMY: QSPI_DUMMY bits (16 clks); spi_out0=0 and spi_dir0=1 from the first DUMMY phase L.
- DATA, single mode: one bit per SCLK from spi_in[1]; 16 clks per byte; spi_dir0 stays 0 and spi_out0=0.
- DATA, quad mode: one nibble per SCLK, spi_in[3:0] = byte[7:4] first, then [3:0]; 4 clks per byte.
- Each byte completes on its final sample edge: the same edge registers rd_data and pulses rd_valid, with rd_id = owner. rd_last is set on byte len (256 when len=0).
- After the last sample: spi_cs=0, sclk=0, spi_dir0=0; GAP lasts CS_GAP clks, then IDLE. The earliest next grant is the edge after GAP ends.
- No preemption; new requests are ignored while busy.
- Request inputs are sampled only at grant; changes afterwards have no effect.
- Outside a transaction: spi_out0=0, spi_dir0=0, sclk=0.
- Address arithmetic is the flash's own (auto-increment); len counter is 9 bits internally.
- Single-mode transaction length = 2*(32 + 8*len) clks. Quad = 2*(40 + 2*len) clks.

Test Plan:
- r0 single, addr 0x000120, len 2; model returns 0xA5,0x3C: CS high for 2*(32+16)=96 clks; MOSI carries 03,00,01,20; rd_valid x2 with 0xA5,0x3C; rd_last on 2nd; r0_ack 1 pulse.
- r1 quad, addr 0x001040, len 4, model nibbles 1..8: CMD 6B; dir0=1 from clk 64; bytes 0x12,0x34,0x56,0x78 with rd_id=1; CS high 2*(40+8)=96 clks.
- r0 and r1 asserted same cycle, FAIR=0, repeated 3 times: r0 granted each time, r1 waits. With FAIR=1: grants alternate 0,1,0; spi_cs low ≥CS_GAP between each.
- len=0, single: 256 rd_valid strobes; rd_last only on the 256th; CS duration 2*(32+2048) clks.
- reset_n low mid-DATA (after byte 3 of 8): spi_cs, sclk, rd_valid drop to 0 asynchronously; no rd_last. After release, a fresh r1 request completes normally.
- Request pulsed during GAP and held: ack only on the edge after GAP ends; no SCLK edge while spi_cs=0.
